mod_updown_counter: RTL and testbench



---
 rtl/counter_pkg.sv | 22 ++
 rtl/count_prescaler.sv | 39 +++
 rtl/mod_updown_counter.sv | 87 ++++++++
 tb/tb_mod_updown_counter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // Bits needed to hold 0..value-1, floored at 1 so a divide-by-1 still has a register.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return (result == 0) ? 1 : result;
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Enable-gated prescaler: step fires combinationally on the last enabled cycle of each PRESCALE period.
module count_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int unsigned   PW   = clog2(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign step = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = step ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with prescaler, parallel load, wrap/saturate mode,
// terminal-count pulse and sticky boundary flag.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_COUNT = 2**WIDTH - 1,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned SATURATE  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;

  // Load also restarts the prescaler so the first step lands PRESCALE edges later.
  count_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (clear | load),
    .en   (en),
    .step (step)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX_V) ? MAX_V : load_val;
    end else if (step) begin
      if (up_dn == DIR_UP) begin
        if (count_q == MAX_V) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (SATURATE == MODE_SAT) ? MAX_V : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d    = 1'b1;
          ovf_d   = 1'b1;
          count_d = (SATURATE == MODE_SAT) ? '0 : MAX_V;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Scoreboard bench for mod_updown_counter across wrap, clamp, saturate and prescale configurations.
module tb_mod_updown_counter;

  typedef struct {
    int         id;
    logic [3:0] cnt;
    logic       tc;
    logic       ovf;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_i [4];
  logic       clr_i [4];
  logic       ld_i  [4];
  logic [3:0] lv_i  [4];
  logic       en_i  [4];
  logic       ud_i  [4];
  logic [3:0] cnt_o [4];
  logic       tc_o  [4];
  logic       ovf_o [4];

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // 0: wrap 0..15, prescale 1
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(1), .SATURATE(0)) u_a (
    .clk(clk), .reset(rst_i[0]), .clear(clr_i[0]), .load(ld_i[0]), .load_val(lv_i[0]),
    .en(en_i[0]), .up_dn(ud_i[0]), .count(cnt_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0]));
  // 1: wrap 0..9
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(0)) u_b (
    .clk(clk), .reset(rst_i[1]), .clear(clr_i[1]), .load(ld_i[1]), .load_val(lv_i[1]),
    .en(en_i[1]), .up_dn(ud_i[1]), .count(cnt_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1]));
  // 2: saturate 0..15
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(1), .SATURATE(1)) u_c (
    .clk(clk), .reset(rst_i[2]), .clear(clr_i[2]), .load(ld_i[2]), .load_val(lv_i[2]),
    .en(en_i[2]), .up_dn(ud_i[2]), .count(cnt_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2]));
  // 3: wrap 0..15, prescale 3
  mod_updown_counter #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(3), .SATURATE(0)) u_d (
    .clk(clk), .reset(rst_i[3]), .clear(clr_i[3]), .load(ld_i[3]), .load_val(lv_i[3]),
    .en(en_i[3]), .up_dn(ud_i[3]), .count(cnt_o[3]), .tc(tc_o[3]), .ovf(ovf_o[3]));

  task automatic cyc(input int id, input logic r, input logic c, input logic l,
                     input logic [3:0] lv, input logic e, input logic u,
                     input logic [3:0] ec, input logic et, input logic eo, input string nm);
    exp_t x;
    @(negedge clk);
    rst_i[id] = r;
    clr_i[id] = c;
    ld_i[id]  = l;
    lv_i[id]  = lv;
    en_i[id]  = e;
    ud_i[id]  = u;
    x.id  = id;
    x.cnt = ec;
    x.tc  = et;
    x.ovf = eo;
    x.nm  = nm;
    q.push_back(x);
  endtask

  // Monitor: every cycle the DUT presents registered outputs; check any pending expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        total++;
        if (cnt_o[x.id] !== x.cnt || tc_o[x.id] !== x.tc || ovf_o[x.id] !== x.ovf) begin
          bad++;
          $display("FAIL %s inst=%0d got count=%0d tc=%b ovf=%b expected count=%0d tc=%b ovf=%b",
                   x.nm, x.id, cnt_o[x.id], tc_o[x.id], ovf_o[x.id], x.cnt, x.tc, x.ovf);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_i[i] = 1'b1;
      clr_i[i] = 1'b0;
      ld_i[i]  = 1'b0;
      lv_i[i]  = 4'd0;
      en_i[i]  = 1'b0;
      ud_i[i]  = 1'b1;
    end

    // Instance 0: full-range wrap, 17 up steps
    cyc(0, 1, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "a_reset0");
    cyc(0, 1, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "a_reset1");
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 0, 0, 4'd0, 1, 1, 4'((i + 1) % 16), (i == 15), (i >= 15), "a_up");
    end
    cyc(0, 0, 0, 0, 4'd0, 0, 1, 4'd1, 0, 1, "a_hold");
    cyc(0, 1, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "a_reset_ovf");

    // Instance 1: modulus 9, down wrap, clamp on load, up wrap at 9
    cyc(1, 1, 0, 0, 4'd0,  0, 0, 4'd0, 0, 0, "b_reset");
    cyc(1, 0, 0, 1, 4'd2,  0, 0, 4'd2, 0, 0, "b_load2");
    cyc(1, 0, 0, 0, 4'd0,  1, 0, 4'd1, 0, 0, "b_dn1");
    cyc(1, 0, 0, 0, 4'd0,  1, 0, 4'd0, 0, 0, "b_dn0");
    cyc(1, 0, 0, 0, 4'd0,  1, 0, 4'd9, 1, 1, "b_dn_wrap");
    cyc(1, 0, 0, 0, 4'd0,  1, 0, 4'd8, 0, 1, "b_dn8");
    cyc(1, 0, 0, 1, 4'd12, 0, 0, 4'd9, 0, 1, "b_load_clamp");
    cyc(1, 0, 0, 0, 4'd0,  1, 1, 4'd0, 1, 1, "b_up_wrap9");
    cyc(1, 0, 0, 0, 4'd0,  1, 1, 4'd1, 0, 1, "b_up1");

    // Instance 2: saturate at both ends
    cyc(2, 1, 0, 0, 4'd0,  0, 1, 4'd0,  0, 0, "c_reset");
    cyc(2, 0, 0, 1, 4'd14, 0, 1, 4'd14, 0, 0, "c_load14");
    cyc(2, 0, 0, 0, 4'd0,  1, 1, 4'd15, 0, 0, "c_up15");
    cyc(2, 0, 0, 0, 4'd0,  1, 1, 4'd15, 1, 1, "c_hold15a");
    cyc(2, 0, 0, 0, 4'd0,  1, 1, 4'd15, 1, 1, "c_hold15b");
    cyc(2, 0, 0, 0, 4'd0,  1, 0, 4'd14, 0, 1, "c_dn14");
    cyc(2, 0, 0, 1, 4'd0,  0, 0, 4'd0,  0, 1, "c_load0");
    cyc(2, 0, 0, 0, 4'd0,  1, 0, 4'd0,  1, 1, "c_hold0");

    // Instance 3: prescale 3, en gaps, clear, mid-prescale direction change, priority
    cyc(3, 1, 0, 0, 4'd0, 0, 1, 4'd0, 0, 0, "d_reset");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "d_e1");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "d_e2");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, "d_e3");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, "d_e4");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, "d_e5");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd2, 0, 0, "d_e6");
    cyc(3, 0, 0, 0, 4'd0, 0, 1, 4'd2, 0, 0, "d_gap1");
    cyc(3, 0, 0, 0, 4'd0, 0, 1, 4'd2, 0, 0, "d_gap2");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd2, 0, 0, "d_e7");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd2, 0, 0, "d_e8");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd3, 0, 0, "d_e9");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd3, 0, 0, "d_mid");
    cyc(3, 0, 1, 0, 4'd0, 1, 1, 4'd0, 0, 0, "d_clear");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "d_c1");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "d_c2");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, "d_c3");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, "d_dir_up1");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, "d_dir_up2");
    cyc(3, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "d_dir_dn_step");
    cyc(3, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "d_dn1");
    cyc(3, 0, 0, 0, 4'd0, 1, 0, 4'd0, 0, 0, "d_dn2");
    cyc(3, 0, 0, 0, 4'd0, 1, 0, 4'd15, 1, 1, "d_dn_wrap");
    cyc(3, 1, 1, 1, 4'd9, 1, 1, 4'd0, 0, 0, "d_all_high");
    cyc(3, 0, 0, 1, 4'd5, 1, 1, 4'd5, 0, 0, "d_load_beats_en");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd5, 0, 0, "d_l1");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd5, 0, 0, "d_l2");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd6, 0, 0, "d_l3");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd6, 0, 0, "d_l4");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd6, 0, 0, "d_l5");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd7, 0, 0, "d_l6");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd7, 0, 0, "d_l7");
    cyc(3, 1, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "d_reset_mid");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "d_r1");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd0, 0, 0, "d_r2");
    cyc(3, 0, 0, 0, 4'd0, 1, 1, 4'd1, 0, 0, "d_r3");

    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected pending=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
